// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//
// Round-robin arbiter sharing one resource between N requesters.
//
// While idle, the request vector is scanned starting at a rotating pointer
// (ptr, ptr+1, ..., N-1, 0, ..., ptr-1). The first asserted request wins and is
// granted on the next edge. The grant is held until one of these happens:
//   - the owner asserts done,
//   - the owner drops its request,
//   - the grant has been visible for MAX_HOLD cycles (forced release).
// After a release the pointer moves to the requester just past the previous
// owner. At least one idle cycle always separates two grants.
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   rst          synchronous active-high reset, overrides everything
//   req[N]       request vector, bit i = requester i wants the resource
//   done         owner finished; only looked at while a grant is active
//   grant[N]     one-hot grant, all zeros when idle
//   grant_pos    binary index of the granted requester, 0 when idle
//   grant_valid  high while a grant is active (equals |grant)
//   timeout      one-cycle pulse when a grant was force-released by MAX_HOLD
//   state_dbg    current FSM state (0 = IDLE, 1 = BUSY)
//
// Handshake: a requester holds req[i] high for as long as it wants the
// resource. Once grant[i] is seen high the requester owns the resource; it
// ends ownership by pulsing done or by dropping req[i]. grant[i] falls on the
// edge after either event. All outputs are registered, so there is no
// combinational path from req or done to any output.
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N        = 4,
    parameter int POS_W    = $clog2(N),
    parameter int MAX_HOLD = 8,
    parameter int HOLD_W   = $clog2(MAX_HOLD + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             done,
    output logic [N-1:0]     grant,
    output logic [POS_W-1:0] grant_pos,
    output logic             grant_valid,
    output logic             timeout,
    output logic             state_dbg
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    localparam logic [POS_W-1:0]  POS_LAST  = POS_W'(N - 1);
    // One extra bit so ptr + i can be compared against N before wrapping.
    localparam logic [POS_W:0]    N_EXT     = (POS_W + 1)'(N);

    state_t            state;
    logic [POS_W-1:0]  ptr;
    logic [HOLD_W-1:0] hcnt;

    assign state_dbg = (state == BUSY);

    // -------------------------------------------------------------------------
    // Winner scan: first set request starting at ptr, wrapping at N.
    // The wrap is done by subtracting N, so N need not be a power of two.
    // -------------------------------------------------------------------------
    logic             win_found;
    logic [POS_W-1:0] win_pos;
    logic [POS_W:0]   cand;

    always_comb begin
        win_found = 1'b0;
        win_pos   = '0;
        cand      = '0;
        for (int i = 0; i < N; i++) begin
            cand = {1'b0, ptr} + (POS_W + 1)'(i);
            if (cand >= N_EXT) begin
                cand = cand - N_EXT;
            end
            if (!win_found && req[cand[POS_W-1:0]]) begin
                win_found = 1'b1;
                win_pos   = cand[POS_W-1:0];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Release conditions while BUSY.
    // -------------------------------------------------------------------------
    logic             rel_done;
    logic             rel_drop;
    logic             rel_hold;
    logic             release_now;
    logic [POS_W-1:0] ptr_next;

    assign rel_done    = done;
    assign rel_drop    = ~req[grant_pos];
    assign rel_hold    = (hcnt == HOLD_LAST);
    assign release_now = rel_done | rel_drop | rel_hold;

    // Next scan starts just past the owner, wrapping explicitly at N-1.
    assign ptr_next = (grant_pos == POS_LAST) ? '0 : grant_pos + POS_W'(1);

    // -------------------------------------------------------------------------
    // FSM with registered outputs.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            hcnt        <= '0;
            grant       <= '0;
            grant_pos   <= '0;
            grant_valid <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    timeout <= 1'b0;
                    hcnt    <= '0;
                    if (win_found) begin
                        state       <= BUSY;
                        grant       <= N'(1) << win_pos;
                        grant_pos   <= win_pos;
                        grant_valid <= 1'b1;
                    end
                end

                BUSY: begin
                    if (release_now) begin
                        state       <= IDLE;
                        grant       <= '0;
                        grant_pos   <= '0;
                        grant_valid <= 1'b0;
                        hcnt        <= '0;
                        ptr         <= ptr_next;
                        // Forced release only when no normal release coincides.
                        timeout     <= rel_hold & ~rel_done & ~rel_drop;
                    end else begin
                        timeout <= 1'b0;
                        if (hcnt != HOLD_LAST) begin
                            hcnt <= hcnt + HOLD_W'(1);
                        end
                    end
                end

                default: begin
                    state       <= IDLE;
                    grant       <= '0;
                    grant_pos   <= '0;
                    grant_valid <= 1'b0;
                    timeout     <= 1'b0;
                    hcnt        <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rr_arbiter
//
// Bench for rr_arbiter (N=4, MAX_HOLD=8). A cycle model tracks who owns the
// resource, for how many cycles the grant has been visible, and where the
// next scan starts; its outputs are compared to the DUT on every cycle.
// Directed sequences with literal expectations come first, then a long
// randomized run.
// -----------------------------------------------------------------------------
module tb_rr_arbiter;

    localparam int N        = 4;
    localparam int POS_W    = 2;
    localparam int MAX_HOLD = 8;

    // ---------------- clock / reset ----------------
    logic             clk  = 1'b0;
    logic             rst  = 1'b1;
    logic [N-1:0]     req  = '0;
    logic             done = 1'b0;
    logic [N-1:0]     grant;
    logic [POS_W-1:0] grant_pos;
    logic             grant_valid;
    logic             timeout;
    logic             state_dbg;

    always #5 clk = ~clk;

    rr_arbiter #(
        .N        (N),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .done        (done),
        .grant       (grant),
        .grant_pos   (grant_pos),
        .grant_valid (grant_valid),
        .timeout     (timeout),
        .state_dbg   (state_dbg)
    );

    // ---------------- scoreboard bookkeeping ----------------
    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // ---------------- reference model ----------------
    // m_age = number of cycles the current grant has been visible.
    int m_busy  = 0;
    int m_owner = 0;
    int m_ptr   = 0;
    int m_age   = 0;
    int m_to    = 0;
    bit model_ok = 1'b0;

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (p + k) % N;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_step();
        int w;
        if (rst) begin
            m_busy = 0; m_owner = 0; m_ptr = 0; m_age = 0; m_to = 0;
            model_ok = 1'b1;
        end else if (m_busy == 0) begin
            m_to = 0;
            w = pick(req, m_ptr);
            if (w >= 0) begin
                m_busy = 1; m_owner = w; m_age = 1;
            end
        end else begin
            if (done || !req[m_owner] || m_age >= MAX_HOLD) begin
                m_to    = (m_age >= MAX_HOLD && !done && req[m_owner]) ? 1 : 0;
                m_ptr   = (m_owner + 1) % N;
                m_busy  = 0;
                m_owner = 0;
                m_age   = 0;
            end else begin
                m_age = m_age + 1;
                m_to  = 0;
            end
        end
    endtask

    // ---------------- per-cycle compare process ----------------
    initial begin
        logic [N-1:0] exp_g;
        forever begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            if (model_ok) begin
                exp_g = '0;
                if (m_busy != 0) exp_g[m_owner] = 1'b1;
                check("cyc_grant", 32'(grant), 32'(exp_g));
                check("cyc_pos", 32'(grant_pos), 32'(m_busy != 0 ? m_owner : 0));
                check("cyc_valid", 32'(grant_valid), 32'(m_busy));
                check("cyc_timeout", 32'(timeout), 32'(m_to));
            end
        end
    end

    // ---------------- directed + random stimulus ----------------
    initial begin
        int  cnt;
        bit  ok;

        // Reset with all requests high.
        rst = 1'b1; req = 4'b1111;
        step(); step();
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_pos", 32'(grant_pos), 32'h0);
        check("rst_valid", 32'(grant_valid), 32'h0);
        check("rst_timeout", 32'(timeout), 32'h0);
        rst = 1'b0; req = 4'b0000;
        step(); step();
        check("idle_grant", 32'(grant), 32'h0);

        // Single request, then pointer check (scan order 3,0).
        req = 4'b0100;
        step();
        check("single_grant", 32'(grant), 32'b0100);
        check("single_pos", 32'(grant_pos), 32'd2);
        check("single_valid", 32'(grant_valid), 32'd1);
        step(); step();
        done = 1'b1;
        step();
        check("single_release", 32'(grant), 32'h0);
        done = 1'b0; req = 4'b0101;
        step();
        check("ptr_scan_grant", 32'(grant), 32'b0001);
        check("ptr_scan_pos", 32'(grant_pos), 32'd0);
        req = 4'b0000;
        step(); step();

        // Round-robin with all requesting.
        rst = 1'b1; step(); rst = 1'b0;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            ok = 1'b0;
            for (int t = 0; t < 10; t++) begin
                if (grant_valid) begin
                    ok = 1'b1;
                    break;
                end
                step();
            end
            check("rr_wait", 32'(ok), 32'd1);
            check("rr_pos", 32'(grant_pos), 32'(k % N));
            done = 1'b1;
            step();
            check("rr_gap", 32'(grant_valid), 32'd0);
            check("rr_no_timeout", 32'(timeout), 32'd0);
            done = 1'b0;
        end
        req = 4'b0000;
        step(); step();

        // Forced release after MAX_HOLD cycles.
        rst = 1'b1; step(); rst = 1'b0;
        req = 4'b0010;
        step();
        cnt = 0;
        for (int t = 0; t < 20; t++) begin
            if (!grant_valid) break;
            cnt++;
            step();
        end
        check("to_len", 32'(cnt), 32'd8);
        check("to_pulse", 32'(timeout), 32'd1);
        step();
        check("to_regrant_valid", 32'(grant_valid), 32'd1);
        check("to_regrant_pos", 32'(grant_pos), 32'd1);
        check("to_pulse_end", 32'(timeout), 32'd0);
        req = 4'b0000;
        step(); step();

        // Owner drops its request.
        rst = 1'b1; step(); rst = 1'b0;
        req = 4'b1000;
        step();
        check("drop_pos3", 32'(grant_pos), 32'd3);
        req = 4'b0001;
        step();
        check("drop_release", 32'(grant_valid), 32'd0);
        check("drop_no_timeout", 32'(timeout), 32'd0);
        step();
        check("drop_regrant_pos", 32'(grant_pos), 32'd0);
        check("drop_regrant_valid", 32'(grant_valid), 32'd1);

        // done coinciding with the last hold cycle: normal release.
        for (int t = 0; t < 7; t++) step();
        check("hold8_still_valid", 32'(grant_valid), 32'd1);
        done = 1'b1;
        step();
        check("done_hold_release", 32'(grant_valid), 32'd0);
        check("done_hold_no_timeout", 32'(timeout), 32'd0);
        done = 1'b0; req = 4'b0000;
        step();

        // Reset in the middle of a grant.
        req = 4'b0100;
        step();
        check("mid_pos2", 32'(grant_pos), 32'd2);
        rst = 1'b1;
        step();
        check("mid_rst_grant", 32'(grant), 32'h0);
        check("mid_rst_pos", 32'(grant_pos), 32'h0);
        check("mid_rst_valid", 32'(grant_valid), 32'h0);
        check("mid_rst_timeout", 32'(timeout), 32'h0);
        rst = 1'b0; req = 4'b1111;
        step();
        check("mid_after_pos", 32'(grant_pos), 32'd0);
        check("mid_after_valid", 32'(grant_valid), 32'd1);

        // Randomized traffic; the compare process does the checking.
        for (int c = 0; c < 4000; c++) begin
            step();
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            done = ($urandom_range(0, 7) == 0);
            rst  = ($urandom_range(0, 299) == 0);
        end
        rst = 1'b0; req = 4'b0000; done = 1'b0;
        step(); step(); step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rr_arbiter.md
Name: rr_arbiter

Overview:
- Round-robin arbiter that shares one resource (e.g. a shifrator/encoder datapath or bus slot) between N requesters.
- Scans requests from a rotating pointer, issues a one-hot grant plus its binary index, and holds the grant until a release event occurs.
- Release events are the owner signalling done, the owner dropping its request, or a hold-time limit expiring.
- Sits between requester clients and the shared resource; grant_pos drives the resource's select/mux input directly.

Parameters:
- N, 4, number of requesters (2..16, need not be a power of 2)
- POS_W, $clog2(N), width of grant_pos and of the internal pointer
- MAX_HOLD, 8, maximum cycles a grant may stay asserted before forced release (>=2)
- HOLD_W, $clog2(MAX_HOLD+1), width of the hold counter

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- req  input  N  request vector; bit i = requester i wants the resource
- done  input  1  owner finished; sampled only while a grant is active
- grant  output  N  one-hot grant, all zeros when idle
- grant_pos  output  POS_W  binary index of granted requester; 0 when idle
- grant_valid  output  1  high while any grant is active (equals |grant)
- timeout  output  1  single-cycle pulse when a grant is force-released by MAX_HOLD

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high; when sampled high, all registers take their reset values on that edge. Reset overrides every other event, including mid-grant.
- Reset values:
  - grant=0, grant_pos=0, grant_valid=0, timeout=0
  - pointer ptr=0, hold counter hcnt=0, state=IDLE
- All outputs are registered; there is no combinational path from req or done to any output.
- State machine has two states, IDLE and BUSY.
- IDLE:
  - If req==0, remain IDLE with outputs zero.
  - Otherwise select winner w = the first set bit of req, scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
  - On the next edge: state=BUSY, grant=1<<w, grant_pos=w, grant_valid=1, hcnt=0.
  - Latency is 1 cycle from req sampled to grant visible.
- BUSY: hcnt increments each cycle, saturating at MAX_HOLD-1. A release occurs in the cycle where any of the following holds:
  - (a) done==1
  - (b) req[grant_pos]==0
  - (c) hcnt==MAX_HOLD-1
- On the release edge:
  - state=IDLE, grant=0, grant_valid=0, grant_pos=0, hcnt=0
  - ptr = (grant_pos+1) wraps to 0 when grant_pos==N-1 (no power-of-2 assumption)
  - timeout=1 for exactly that cycle only if (c) holds and neither (a) nor (b) does
- Timing after release: grant drops 1 cycle after the release condition. At least one idle cycle separates consecutive grants, so the earliest next grant is 2 cycles after the release condition.
- Fairness: with all N requesters continuously asserting, grants rotate 0,1,...,N-1,0,... with no requester skipped.
- Ignored inputs:
  - done while IDLE has no effect.
  - Changes on req bits other than grant_pos during BUSY do not affect the current grant.
- Simultaneous release conditions: (a) and (c) together count as a normal release with no timeout pulse; likewise (b) and (c).
- grant is always one-hot or zero; grant_valid==|grant and grant[grant_pos]==grant_valid at all times.

Test Plan:
- Reset/idle (N=4, MAX_HOLD=8): rst=1 for 2 cycles with req=4'b1111 -> grant=0, grant_pos=0, grant_valid=0, timeout=0. Release rst with req=0 -> outputs stay 0.
- Single request: req=4'b0100 at cycle t -> grant=4'b0100, grant_pos=2, valid=1 at t+1. done=1 at t+3 -> grant=0 at t+4. Next ptr=3, checked by req=4'b0101 giving grant_pos=0 because scan order is 3,0.
- Round-robin: req=4'b1111 held, done pulsed 1 cycle after each grant -> grant_pos sequence 0,1,2,3,0 with one idle cycle between grants and no timeout.
- Timeout: req=4'b0010 held, done never asserted -> grant_pos=1 for exactly 8 cycles, timeout=1 on the first cycle grant=0, then regrant of requester 1 two cycles later.
- Request drop: grant to requester 3, then req[3] falls while req[0] stays high -> grant=0 next cycle, grant_pos=0 granted the cycle after. Also: done and hcnt==7 in the same cycle -> timeout stays 0.
- Mid-grant reset: grant active on requester 2, rst=1 for 1 cycle -> all outputs 0 next edge. ptr returns to 0, so req=4'b1111 afterwards gives grant_pos=0.
